// File: rtl/fetch_unit_pkg.sv
// Shared types, FSM state codes and predecode match tables for the fetch stage.
// The match masks/values are identical to the encodings used by decode.
package fetch_unit_pkg;

   localparam int INSNBITS_SIZE = 32;
   localparam int GPR_SIZE      = 64;
   localparam int IMM26_W       = 26;

   typedef logic [INSNBITS_SIZE-1:0] insn_t;
   typedef logic [GPR_SIZE-1:0]      gpr_t;

   // Fetch FSM state codes, kept as plain constants so legacy tools can read them.
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t FS_RUN           = 2'd0;
   localparam fetch_state_t FS_WAIT_REDIRECT = 2'd1;
   localparam fetch_state_t FS_HALTED        = 2'd2;

   // B / BL: opcode in bits [31:26], imm26 below.
   localparam insn_t UNCOND_MASK = 32'hFC00_0000;
   localparam insn_t B_VAL       = 32'h1400_0000;
   localparam insn_t BL_VAL      = 32'h9400_0000;

   // BR / BLR / RET: everything fixed except Rn in bits [9:5].
   localparam insn_t INDIRECT_MASK = 32'hFFFF_FC1F;
   localparam insn_t BR_VAL        = 32'hD61F_0000;
   localparam insn_t BLR_VAL       = 32'hD63F_0000;
   localparam insn_t RET_VAL       = 32'hD65F_0000;

   // HLT: imm16 in bits [20:5] is ignored.
   localparam insn_t HLT_MASK = 32'hFFE0_001F;
   localparam insn_t HLT_VAL  = 32'hD440_0000;

   // Match tables walked by the predecoder; entry 0 is the rightmost element.
   localparam int N_UNCOND   = 2;
   localparam int N_INDIRECT = 3;
   localparam logic [N_UNCOND-1:0][INSNBITS_SIZE-1:0]   UNCOND_VALS   = {BL_VAL, B_VAL};
   localparam logic [N_INDIRECT-1:0][INSNBITS_SIZE-1:0] INDIRECT_VALS = {RET_VAL, BLR_VAL, BR_VAL};

   // True when the masked instruction equals the given encoding.
   function automatic logic insn_match(input insn_t insn, input insn_t mask, input insn_t val);
      return (insn & mask) == val;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-dispatch handoff.
// master = fetch unit, slave = instruction memory / dispatch side.
interface fetch_unit_if #(
   parameter int IADDR_W = 64
);
   import fetch_unit_pkg::*;

   logic               out_imem_req;
   logic [IADDR_W-1:0] out_imem_addr;
   insn_t              in_imem_rdata;
   insn_t              out_fetch_insnbits;
   logic               out_fetch_done;
   gpr_t               out_fetch_branch_PC;

   modport master (
      output out_imem_req,
      output out_imem_addr,
      input  in_imem_rdata,
      output out_fetch_insnbits,
      output out_fetch_done,
      output out_fetch_branch_PC
   );

   modport slave (
      input  out_imem_req,
      input  out_imem_addr,
      output in_imem_rdata,
      input  out_fetch_insnbits,
      input  out_fetch_done,
      input  out_fetch_branch_PC
   );

endinterface

// File: rtl/fetch_unit_predecode.sv
// Combinational predecode of a delivered word: flags control-flow classes that
// change fetch direction and computes the direct-branch target.
module fetch_unit_predecode
   import fetch_unit_pkg::*;
(
   input  insn_t i_insnbits,
   input  gpr_t  i_pc,
   output logic  o_is_uncond,
   output logic  o_is_indirect,
   output logic  o_is_halt,
   output gpr_t  o_taken_target
);

   logic [N_UNCOND-1:0]   w_uncond_hit;
   logic [N_INDIRECT-1:0] w_indirect_hit;
   gpr_t                  w_offset;

   genvar gi;
   generate
      // One comparator per direct unconditional branch encoding (B, BL).
      for (gi = 0; gi < N_UNCOND; gi++) begin : g_uncond
         assign w_uncond_hit[gi] = insn_match(i_insnbits, UNCOND_MASK, UNCOND_VALS[gi]);
      end
      // One comparator per register-indirect branch encoding (BR, BLR, RET).
      for (gi = 0; gi < N_INDIRECT; gi++) begin : g_indirect
         assign w_indirect_hit[gi] = insn_match(i_insnbits, INDIRECT_MASK, INDIRECT_VALS[gi]);
      end
   endgenerate

   assign o_is_uncond   = |w_uncond_hit;
   assign o_is_indirect = |w_indirect_hit;
   assign o_is_halt     = insn_match(i_insnbits, HLT_MASK, HLT_VAL);

   // Word offset: sign-extended imm26 scaled by 4; the add wraps modulo 2^64.
   assign w_offset = {{(GPR_SIZE-IMM26_W-2){i_insnbits[IMM26_W-1]}},
                      i_insnbits[IMM26_W-1:0], 2'b00};
   assign o_taken_target = i_pc + w_offset;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues at most one request per cycle to a
// 1-cycle-latency imem, holds one word in a skid buffer under backpressure, and
// redirects itself on B/BL, stops on HLT and waits on BR/BLR/RET for commit.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter gpr_t RESET_PC = '0,
   parameter int   IADDR_W  = 64
)(
   input  logic         in_clk,
   input  logic         in_rst,
   input  logic         in_stall,
   input  logic         in_redirect_valid,
   input  gpr_t         in_redirect_PC,
   fetch_unit_if.master bus,
   output logic         out_halted
);

   // Architectural fetch state.
   fetch_state_t r_state;
   gpr_t         r_fetch_pc;

   // The single outstanding imem request.
   logic         r_inflight_valid;
   gpr_t         r_inflight_pc;
   logic         r_inflight_squash;

   // One-entry skid buffer for a response that arrives while stalled.
   logic         r_skid_valid;
   insn_t        r_skid_insn;
   gpr_t         r_skid_pc;

   // Registered dispatch outputs.
   logic         r_fetch_done;
   insn_t        r_fetch_insnbits;
   gpr_t         r_fetch_branch_PC;
   logic         r_halted;

   // Next-state values.
   fetch_state_t w_state_next;
   gpr_t         w_fetch_pc_next;
   logic         w_inflight_valid_next;
   gpr_t         w_inflight_pc_next;
   logic         w_inflight_squash_next;
   logic         w_skid_valid_next;
   insn_t        w_skid_insn_next;
   gpr_t         w_skid_pc_next;
   insn_t        w_fetch_insnbits_next;
   gpr_t         w_fetch_branch_PC_next;

   // Issue / response / delivery decisions.
   logic         w_issue;
   logic         w_resp_live;
   logic         w_can_deliver;
   logic         w_dlv_skid;
   logic         w_dlv_resp;
   logic         w_deliver;
   logic         w_skid_capture;
   insn_t        w_dlv_insn;
   gpr_t         w_dlv_pc;

   // Predecode of the word being delivered this cycle.
   logic         w_pd_uncond;
   logic         w_pd_indirect;
   logic         w_pd_halt;
   gpr_t         w_pd_target;
   logic         w_dlv_uncond;
   logic         w_dlv_indirect;
   logic         w_dlv_halt;
   logic         w_dlv_turns;

   // A request goes out only in RUN and only when nothing overrides the PC this cycle.
   assign w_issue = (r_state == FS_RUN) & ~in_stall & ~in_redirect_valid & ~in_rst;

   // A response is usable unless its request was issued down a path we have left.
   assign w_resp_live   = r_inflight_valid & ~r_inflight_squash;
   assign w_can_deliver = ~in_redirect_valid & ~in_stall;

   // The skid word is older than any live response, so it goes first. Both cannot
   // be pending at once because nothing issues during a stall.
   assign w_dlv_skid     = w_can_deliver & r_skid_valid;
   assign w_dlv_resp     = w_can_deliver & ~r_skid_valid & w_resp_live;
   assign w_deliver      = w_dlv_skid | w_dlv_resp;
   assign w_skid_capture = ~in_redirect_valid & in_stall & w_resp_live;

   assign w_dlv_insn = r_skid_valid ? r_skid_insn : bus.in_imem_rdata;
   assign w_dlv_pc   = r_skid_valid ? r_skid_pc   : r_inflight_pc;

   fetch_unit_predecode u_predecode (
      .i_insnbits     (w_dlv_insn),
      .i_pc           (w_dlv_pc),
      .o_is_uncond    (w_pd_uncond),
      .o_is_indirect  (w_pd_indirect),
      .o_is_halt      (w_pd_halt),
      .o_taken_target (w_pd_target)
   );

   assign w_dlv_uncond   = w_deliver & w_pd_uncond;
   assign w_dlv_indirect = w_deliver & w_pd_indirect;
   assign w_dlv_halt     = w_deliver & w_pd_halt;
   // Any of these makes the sequential request issued alongside it wrong-path.
   assign w_dlv_turns    = w_dlv_uncond | w_dlv_indirect | w_dlv_halt;

   // Next-state selection: redirect overrides everything except reset.
   always_comb begin
      w_state_next           = r_state;
      w_fetch_pc_next        = r_fetch_pc;
      w_inflight_valid_next  = w_issue;
      w_inflight_pc_next     = r_fetch_pc;
      w_inflight_squash_next = w_issue & w_dlv_turns;
      w_skid_valid_next      = r_skid_valid;
      w_skid_insn_next       = r_skid_insn;
      w_skid_pc_next         = r_skid_pc;
      w_fetch_insnbits_next  = r_fetch_insnbits;
      w_fetch_branch_PC_next = r_fetch_branch_PC;

      if (in_redirect_valid) begin
         // HLT or an indirect wait may have been wrong-path, so resume from any state.
         w_state_next           = FS_RUN;
         w_fetch_pc_next        = in_redirect_PC;
         w_inflight_valid_next  = 1'b0;
         w_inflight_squash_next = 1'b0;
         w_skid_valid_next      = 1'b0;
      end else begin
         if (w_dlv_halt) begin
            w_state_next = FS_HALTED;
         end else if (w_dlv_indirect) begin
            w_state_next = FS_WAIT_REDIRECT;
         end

         // A taken B/BL retargets the PC; the request issued this cycle is squashed above.
         if (w_dlv_uncond) begin
            w_fetch_pc_next = w_pd_target;
         end else if (w_issue) begin
            w_fetch_pc_next = r_fetch_pc + 64'd4;
         end

         if (w_skid_capture) begin
            w_skid_valid_next = 1'b1;
            w_skid_insn_next  = bus.in_imem_rdata;
            w_skid_pc_next    = r_inflight_pc;
         end else if (w_dlv_skid) begin
            w_skid_valid_next = 1'b0;
         end

         if (w_deliver) begin
            w_fetch_insnbits_next  = w_dlv_insn;
            w_fetch_branch_PC_next = w_dlv_pc;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state           <= FS_RUN;
         r_fetch_pc        <= RESET_PC;
         r_inflight_valid  <= 1'b0;
         r_inflight_pc     <= '0;
         r_inflight_squash <= 1'b0;
         r_skid_valid      <= 1'b0;
         r_skid_insn       <= '0;
         r_skid_pc         <= '0;
         r_fetch_done      <= 1'b0;
         r_fetch_insnbits  <= '0;
         r_fetch_branch_PC <= '0;
         r_halted          <= 1'b0;
      end else begin
         r_state           <= w_state_next;
         r_fetch_pc        <= w_fetch_pc_next;
         r_inflight_valid  <= w_inflight_valid_next;
         r_inflight_pc     <= w_inflight_pc_next;
         r_inflight_squash <= w_inflight_squash_next;
         r_skid_valid      <= w_skid_valid_next;
         r_skid_insn       <= w_skid_insn_next;
         r_skid_pc         <= w_skid_pc_next;
         r_fetch_done      <= w_deliver;
         r_fetch_insnbits  <= w_fetch_insnbits_next;
         r_fetch_branch_PC <= w_fetch_branch_PC_next;
         r_halted          <= (w_state_next == FS_HALTED);
      end
   end

   assign bus.out_imem_req        = w_issue;
   assign bus.out_imem_addr       = r_fetch_pc[IADDR_W-1:0];
   assign bus.out_fetch_done      = r_fetch_done;
   assign bus.out_fetch_insnbits  = r_fetch_insnbits;
   assign bus.out_fetch_branch_PC = r_fetch_branch_PC;
   assign out_halted              = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural imem, an expected-PC scoreboard checked on
// every delivery, and directed cycle checks around branches, stalls and redirects.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] NOP_W = 32'hD503_201F;
   localparam logic [31:0] HLT_W = 32'hD440_0000;

   logic clk = 1'b0;
   logic rst;
   logic stall;
   logic redir_valid;
   gpr_t redir_pc;
   logic halted;

   fetch_unit_if #(.IADDR_W(64)) bus ();

   fetch_unit #(
      .RESET_PC (64'h1000),
      .IADDR_W  (64)
   ) dut (
      .in_clk            (clk),
      .in_rst            (rst),
      .in_stall          (stall),
      .in_redirect_valid (redir_valid),
      .in_redirect_PC    (redir_pc),
      .bus               (bus),
      .out_halted        (halted)
   );

   always #5 clk = ~clk;

   logic [31:0] prog [logic [63:0]];
   gpr_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   int          req_count = 0;

   function automatic logic [31:0] mem_rd(input gpr_t a);
      return prog.exists(a) ? prog[a] : NOP_W;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Instruction memory: one-cycle registered read.
   always @(posedge clk) begin
      bus.in_imem_rdata <= bus.out_imem_req ? mem_rd(bus.out_imem_addr) : 32'hDEAD_BEEF;
   end

   // Delivery monitor: every delivered word must be the next expected PC.
   always @(negedge clk) begin
      gpr_t exp_pc;
      if (bus.out_imem_req) req_count++;
      if (!rst && bus.out_fetch_done) begin
         exp_pc = (sb.size() != 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
         $display("DLV t=%0t pc=%h insn=%h", $time, bus.out_fetch_branch_PC, bus.out_fetch_insnbits);
         chk("dlv_pc", bus.out_fetch_branch_PC, exp_pc);
         chk("dlv_insn", 64'(bus.out_fetch_insnbits), 64'(mem_rd(exp_pc)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_halt(input string tag);
      int n;
      n = 0;
      tick();
      while (!halted && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 64'(halted), 64'd1);
      tick();
      chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
   endtask

   // One-cycle redirect pulse; returns at the start of the first cycle after it.
   task automatic redirect(input gpr_t pc);
      redir_valid = 1'b1;
      redir_pc    = pc;
      @(negedge clk);
      chk("redir_req", 64'(bus.out_imem_req), 64'd0);
      tick();
      redir_valid = 1'b0;
   endtask

   // Redirect arriving together with a stall while a BL is in flight or in the skid.
   task automatic run_redirect_over_bl(input bit via_skid);
      prog[64'h6000] = 32'h9400_0040;
      prog[64'h7004] = HLT_W;
      sb.push_back(64'h7000);
      sb.push_back(64'h7004);
      redirect(64'h6000);
      tick();
      if (via_skid) begin
         stall = 1'b1;
         tick();
      end
      stall       = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 64'h7000;
      @(negedge clk);
      chk("t6_req", 64'(bus.out_imem_req), 64'd0);
      tick();
      stall       = 1'b0;
      redir_valid = 1'b0;
      @(negedge clk);
      chk("t6_addr", bus.out_imem_addr, 64'h7000);
      chk("t6_issue", 64'(bus.out_imem_req), 64'd1);
      wait_halt(via_skid ? "t6_skid_halt" : "t6_live_halt");
   endtask

   initial begin
      int rc0;
      logic [63:0] t2_addr [5];
      logic        t2_done [5];
      t2_addr = '{64'h1000, 64'h1004, 64'h1040, 64'h1044, 64'h1048};
      t2_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_pc = '0;

      // Test 1: reset state, then a straight NOP run ending in HLT.
      repeat (3) tick();
      @(negedge clk);
      chk("rst_done", 64'(bus.out_fetch_done), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_req", 64'(bus.out_imem_req), 64'd0);
      prog[64'h1020] = HLT_W;
      for (int a = 0; a <= 8; a++) sb.push_back(64'h1000 + 64'(a * 4));
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t1_done", 64'(bus.out_fetch_done), 64'(k >= 2));
         chk("t1_addr", bus.out_imem_addr, 64'h1000 + 64'(4 * k));
         tick();
      end
      wait_halt("t1_halt");

      // Test 2: B #+0x40 at 0x1000, reset out of the halted state.
      prog[64'h1000] = 32'h1400_0010;
      prog[64'h1048] = HLT_W;
      sb.push_back(64'h1000);
      sb.push_back(64'h1040);
      sb.push_back(64'h1044);
      sb.push_back(64'h1048);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t2_rst_halted", 64'(halted), 64'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t2_done", 64'(bus.out_fetch_done), 64'(t2_done[k]));
         chk("t2_addr", bus.out_imem_addr, t2_addr[k]);
         tick();
      end
      wait_halt("t2_halt");

      // Test 3: three-cycle stall with a response in flight.
      prog[64'h4010] = HLT_W;
      for (int a = 0; a <= 4; a++) sb.push_back(64'h4000 + 64'(a * 4));
      redirect(64'h4000);
      @(negedge clk);
      chk("t3_addr0", bus.out_imem_addr, 64'h4000);
      tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_stall_req", 64'(bus.out_imem_req), 64'd0);
         chk("t3_stall_done", 64'(bus.out_fetch_done), 64'd0);
         tick();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("t3_rel_req", 64'(bus.out_imem_req), 64'd1);
      chk("t3_rel_addr", bus.out_imem_addr, 64'h4004);
      wait_halt("t3_halt");

      // Test 4: BR X1 parks fetch until commit redirects it.
      prog[64'h2000] = 32'hD61F_0020;
      prog[64'h3004] = HLT_W;
      sb.push_back(64'h2000);
      redirect(64'h2000);
      tick();
      tick();
      rc0 = req_count;
      repeat (10) tick();
      chk("t4_no_req", 64'(req_count - rc0), 64'd0);
      chk("t4_halted", 64'(halted), 64'd0);
      chk("t4_sb", 64'(sb.size()), 64'd0);
      sb.push_back(64'h3000);
      sb.push_back(64'h3004);
      redirect(64'h3000);
      @(negedge clk);
      chk("t4_addr", bus.out_imem_addr, 64'h3000);
      wait_halt("t4_halt");

      // Test 5: halted stays quiet, then a redirect resumes at 0x500.
      rc0 = req_count;
      repeat (10) tick();
      chk("t5_no_req", 64'(req_count - rc0), 64'd0);
      chk("t5_halted", 64'(halted), 64'd1);
      prog[64'h508] = HLT_W;
      sb.push_back(64'h500);
      sb.push_back(64'h504);
      sb.push_back(64'h508);
      redirect(64'h500);
      @(negedge clk);
      chk("t5_addr", bus.out_imem_addr, 64'h500);
      chk("t5_unhalt", 64'(halted), 64'd0);
      wait_halt("t5_halt");

      // Test 6: redirect wins over a stalled BL, both live and skidded.
      run_redirect_over_bl(1'b0);
      run_redirect_over_bl(1'b1);

      chk("end_sb", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
